// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding,
// counter width and the default stability window.
package btn_debounce_pkg;

    localparam int unsigned CNT_W                   = 24;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHK_HI    = 2'd1,
        STABLE_HI = 2'd2,
        CHK_LO    = 2'd3
    } deb_state_e;

    // Terminal count reached on the last stable cycle of the window.
    function automatic logic [CNT_W-1:0] last_count(input int unsigned cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, 4-state stability FSM with a
// 24-bit window counter, and registered level/press/release outputs.
module debounce_ch
    import btn_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = last_count(DEBOUNCE_CYCLES);

    logic [1:0]       sync_q;
    logic             sync;
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    assign sync = sync_q[1];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q    <= '0;
            state_q   <= STABLE_LO;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], btn_i};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Counter leaves the CHK states at CNT_LAST, so it can never wrap.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            STABLE_LO: begin
                if (sync) begin
                    state_d = CHK_HI;
                    cnt_d   = '0;
                end
            end
            CHK_HI: begin
                if (!sync) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STABLE_HI: begin
                if (!sync) begin
                    state_d = CHK_LO;
                    cnt_d   = '0;
                end
            end
            CHK_LO: begin
                if (sync) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = STABLE_LO;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/btn_debounce.sv
// N_BTN independent push-button debouncers sharing one clock and reset;
// every output comes straight from a channel register.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int unsigned N_BTN           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             CLK50MHz,
    input  logic             RST_N,
    input  logic [N_BTN-1:0] BTN,
    output logic [N_BTN-1:0] BTN_LEVEL,
    output logic [N_BTN-1:0] BTN_PRESS,
    output logic [N_BTN-1:0] BTN_RELEASE
);

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk_i    (CLK50MHz),
            .rst_ni   (RST_N),
            .btn_i    (BTN[g]),
            .level_o  (BTN_LEVEL[g]),
            .press_o  (BTN_PRESS[g]),
            .release_o(BTN_RELEASE[g])
        );
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: two instances (window 4 and window 1) checked every
// cycle against a window-based model, plus literal expectations per scenario.
module tb_btn_debounce;

    localparam int unsigned NB = 4;
    localparam int unsigned DA = 4;
    localparam int unsigned DB = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] btn;
    logic [NB-1:0] lvl_a, prs_a, rel_a;
    logic [NB-1:0] lvl_b, prs_b, rel_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #10 clk = ~clk;

    btn_debounce #(.N_BTN(NB), .DEBOUNCE_CYCLES(DA)) dut_a (
        .CLK50MHz(clk), .RST_N(rst_n), .BTN(btn),
        .BTN_LEVEL(lvl_a), .BTN_PRESS(prs_a), .BTN_RELEASE(rel_a)
    );

    btn_debounce #(.N_BTN(NB), .DEBOUNCE_CYCLES(DB)) dut_b (
        .CLK50MHz(clk), .RST_N(rst_n), .BTN(btn),
        .BTN_LEVEL(lvl_b), .BTN_PRESS(prs_b), .BTN_RELEASE(rel_b)
    );

    // Model: raw button passes a 2-deep delay; the level flips once the last
    // (window+1) samples reaching the decision logic all disagree with it.
    int unsigned   win [2] = '{DA, DB};
    logic [NB-1:0] p1 = '0;
    logic [NB-1:0] p2 = '0;
    logic [15:0]   hist  [2][NB];
    logic [NB-1:0] m_lvl [2];
    logic [NB-1:0] m_prs [2];
    logic [NB-1:0] m_rel [2];

    function automatic bit all_differ(input logic [15:0] h, input int unsigned n, input logic lv);
        for (int unsigned i = 0; i < n; i++) begin
            if (h[i] == lv) return 1'b0;
        end
        return 1'b1;
    endfunction

    initial begin
        for (int c = 0; c < 2; c++) begin
            m_lvl[c] = '0; m_prs[c] = '0; m_rel[c] = '0;
            for (int ch = 0; ch < NB; ch++) hist[c][ch] = '0;
        end
        forever begin
            @(posedge clk);
            for (int c = 0; c < 2; c++) begin
                m_prs[c] = '0;
                m_rel[c] = '0;
                for (int ch = 0; ch < NB; ch++) begin
                    if (!rst_n) begin
                        hist[c][ch]  = '0;
                        m_lvl[c][ch] = 1'b0;
                    end else begin
                        hist[c][ch] = {hist[c][ch][14:0], p2[ch]};
                        if (all_differ(hist[c][ch], win[c] + 1, m_lvl[c][ch])) begin
                            m_lvl[c][ch] = ~m_lvl[c][ch];
                            if (m_lvl[c][ch]) m_prs[c][ch] = 1'b1;
                            else              m_rel[c][ch] = 1'b1;
                        end
                    end
                end
            end
            if (!rst_n) begin
                p1 = '0;
                p2 = '0;
            end else begin
                p2 = p1;
                p1 = btn;
            end
        end
    end

    function automatic logic [11:0] vec_a();
        return {lvl_a, prs_a, rel_a};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got {lvl,prs,rel}=%h expected %h", name, $time, act, exp);
        end
    endtask

    // Advance one clock and compare both instances against the model.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        check("model_d4", {lvl_a, prs_a, rel_a}, {m_lvl[0], m_prs[0], m_rel[0]});
        check("model_d1", {lvl_b, prs_b, rel_b}, {m_lvl[1], m_prs[1], m_rel[1]});
    endtask

    task automatic do_reset();
        btn   = '0;
        rst_n = 1'b0;
        cycle();
        check("reset_state", vec_a(), 12'h000);
        cycle();
        check("reset_state", vec_a(), 12'h000);
        rst_n = 1'b1;
        cycle();
        check("post_reset", vec_a(), 12'h000);
    endtask

    // Expected vector when bit mask m is debounced high at cycle 7 of a window.
    function automatic logic [11:0] rise_exp(input int i, input logic [3:0] m);
        if (i < 7)  return 12'h000;
        if (i == 7) return {m, m, 4'h0};
        return {m, 4'h0, 4'h0};
    endfunction

    initial begin
        int pulses;
        int press_at;
        int mode;
        rst_n = 1'b0;
        btn   = '0;
        @(negedge clk);

        // Clean press on channel 0
        do_reset();
        btn[0] = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            check("clean_press", vec_a(), rise_exp(i, 4'h1));
        end

        // Three-clock glitch on channel 1
        do_reset();
        btn[1] = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            if (i == 4) btn[1] = 1'b0;
            cycle();
            check("glitch", vec_a(), 12'h000);
        end

        // Release on channel 2
        do_reset();
        btn[2] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            cycle();
            check("release_setup", vec_a(), rise_exp(i, 4'h4));
        end
        btn[2] = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            check("release", vec_a(),
                  (i < 7) ? 12'h400 : (i == 7) ? 12'h004 : 12'h000);
        end

        // All four channels at once
        do_reset();
        btn = 4'hF;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            check("simultaneous", vec_a(), rise_exp(i, 4'hF));
        end

        // Reset mid-debounce with channel 3 held through it
        do_reset();
        btn[3] = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cycle();
            check("pre_reset_hold", vec_a(), 12'h000);
        end
        rst_n = 1'b0;
        cycle();
        check("mid_reset", vec_a(), 12'h000);
        rst_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            cycle();
            check("held_through_reset", vec_a(), rise_exp(i, 4'h8));
        end

        // Bounce train on channel 0, then stable high
        do_reset();
        for (int i = 0; i < 30; i++) begin
            btn[0] = ((i / 2) % 2) == 1;
            cycle();
            check("bounce_train", vec_a(), 12'h000);
        end
        btn[0]   = 1'b1;
        pulses   = 0;
        press_at = 0;
        for (int i = 1; i <= 12; i++) begin
            cycle();
            if (prs_a[0]) begin
                pulses++;
                press_at = i;
            end
        end
        check("bounce_pulses", 12'(pulses), 12'd1);
        check("bounce_latency", 12'(press_at), 12'd7);

        // Randomized activity with bursts of varying bounce rate and rare resets
        do_reset();
        mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) mode = int'($urandom_range(0, 2));
            for (int ch = 0; ch < NB; ch++) begin
                case (mode)
                    0:       if ($urandom_range(0, 1) == 0)  btn[ch] = ~btn[ch];
                    1:       if ($urandom_range(0, 7) == 0)  btn[ch] = ~btn[ch];
                    default: if ($urandom_range(0, 39) == 0) btn[ch] = ~btn[ch];
                endcase
            end
            rst_n = ($urandom_range(0, 299) != 0);
            cycle();
        end
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
